// File: rtl/fft_r2_sched.sv
// fft_r2_sched: address/control sequencer for an in-place radix-2 DIT FFT
// of N = 2^LOG2N points using a single shared butterfly unit.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             launch a transform (sampled only in IDLE)
//   busy, done        status; done pulses for one cycle at completion
//   stage             current stage index
//   rd_en             one butterfly issued this cycle
//   rd_addr_a/b       upper/lower butterfly read addresses
//   tw_idx            twiddle ROM index (W_N^tw_idx)
//   wr_en             butterfly results written this cycle
//   wr_addr_a/b       write-back addresses for y1/y2
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one butterfly read per cycle for stage s
// DRAIN | no reads; lets the pipeline commit stage s before stage s+1 reads
// DONE  | one-cycle completion pulse

module fft_r2_sched #(
    parameter int unsigned LOG2N    = 3,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);

    localparam int unsigned DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
    localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [DW-1:0]    d_q, d_d;

    logic             pipe_en_q [PIPE_LAT];
    logic             pipe_en_d [PIPE_LAT];
    logic [LOG2N-1:0] pipe_a_q  [PIPE_LAT];
    logic [LOG2N-1:0] pipe_a_d  [PIPE_LAT];
    logic [LOG2N-1:0] pipe_b_q  [PIPE_LAT];
    logic [LOG2N-1:0] pipe_b_d  [PIPE_LAT];

    logic [LOG2N-1:0] k_ext, half, pos, grp, addr_a;

    // State and counter registers, plus the write-address delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            d_q     <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_en_q[i] <= 1'b0;
                pipe_a_q[i]  <= '0;
                pipe_b_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            d_q     <= d_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_en_q[i] <= pipe_en_d[i];
                pipe_a_q[i]  <= pipe_a_d[i];
                pipe_b_q[i]  <= pipe_b_d[i];
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        d_d     = d_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            ST_ISSUE: begin
                k_d = k_q + 1'b1;
                if (&k_q) begin
                    k_d     = '0;
                    d_d     = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                d_d = d_q + 1'b1;
                if (d_q == D_LAST) begin
                    if (s_q != S_LAST) begin
                        s_d     = s_q + 4'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Butterfly addressing: k splits into group (upper bits) and position
    // within the group (low s bits); the pair spans 2*half addresses.
    always_comb begin
        k_ext  = {1'b0, k_q};
        half   = LOG2N'(1) << s_q;
        pos    = k_ext & (half - LOG2N'(1));
        grp    = k_ext >> s_q;
        addr_a = (grp << (s_q + 4'd1)) | pos;
    end

    // Outputs.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        stage     = (state_q == ST_IDLE) ? 4'd0 : s_q;
        rd_en     = (state_q == ST_ISSUE);
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        if (rd_en) begin
            rd_addr_a = addr_a;
            rd_addr_b = addr_a + half;
            // pos < 2^s, so its top bit is always clear here.
            tw_idx    = pos[LOG2N-2:0] << (S_LAST - s_q);
        end
        wr_en     = pipe_en_q[PIPE_LAT-1];
        wr_addr_a = pipe_a_q[PIPE_LAT-1];
        wr_addr_b = pipe_b_q[PIPE_LAT-1];
    end

    // Delay line input side: tap 0 captures this cycle's read.
    always_comb begin
        pipe_en_d[0] = rd_en;
        pipe_a_d[0]  = rd_addr_a;
        pipe_b_d[0]  = rd_addr_b;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_en_d[i] = pipe_en_q[i-1];
            pipe_a_d[i]  = pipe_a_q[i-1];
            pipe_b_d[i]  = pipe_b_q[i-1];
        end
    end

endmodule

// File: tb/tb_fft_r2_sched.sv
module tb_fft_r2_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: LOG2N=3, PIPE_LAT=2
    logic       rst_a, start_a, busy_a, done_a, rd_en_a, wr_en_a;
    logic [3:0] stage_a;
    logic [2:0] ra_a, rb_a, wa_a, wb_a;
    logic [1:0] tw_a;

    // DUT B: LOG2N=4, PIPE_LAT=1
    logic       rst_b, start_b, busy_b, done_b, rd_en_b, wr_en_b;
    logic [3:0] stage_b;
    logic [3:0] ra_b, rb_b, wa_b, wb_b;
    logic [2:0] tw_b;

    fft_r2_sched #(.LOG2N(3), .PIPE_LAT(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .stage(stage_a), .rd_en(rd_en_a), .rd_addr_a(ra_a), .rd_addr_b(rb_a),
        .tw_idx(tw_a), .wr_en(wr_en_a), .wr_addr_a(wa_a), .wr_addr_b(wb_a)
    );

    fft_r2_sched #(.LOG2N(4), .PIPE_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .stage(stage_b), .rd_en(rd_en_b), .rd_addr_a(ra_b), .rd_addr_b(rb_b),
        .tw_idx(tw_b), .wr_en(wr_en_b), .wr_addr_a(wa_b), .wr_addr_b(wb_b)
    );

    // Hand-computed butterfly sequence for N=8, stages 0..2.
    logic [2:0] tab_a  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] tab_b  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [1:0] tab_tw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    // Expected DUT A outputs in cycle c of a clean run (start sampled in cycle 0).
    // Each stage takes 6 cycles: 4 ISSUE then 2 DRAIN; DONE in cycle 19.
    function automatic logic [21:0] exp_a_vec(input int c);
        logic       busy, dn, rd, wr;
        logic [3:0] stg;
        logic [2:0] ra, rb, wa, wb;
        logic [1:0] tw;
        int         st, ix;
        busy = (c >= 1 && c <= 19);
        dn   = (c == 19);
        rd = 1'b0; wr = 1'b0; stg = 4'd0;
        ra = 3'd0; rb = 3'd0; wa = 3'd0; wb = 3'd0; tw = 2'd0;
        if (c >= 1 && c <= 18) begin
            st  = (c - 1) / 6;
            ix  = (c - 1) % 6;
            stg = 4'(st);
            if (ix < 4) begin
                rd = 1'b1;
                ra = tab_a[st*4+ix];
                rb = tab_b[st*4+ix];
                tw = tab_tw[st*4+ix];
            end
        end
        if (c == 19) stg = 4'd2;
        if (c >= 3 && c <= 20) begin
            st = (c - 3) / 6;
            ix = (c - 3) % 6;
            if (ix < 4) begin
                wr = 1'b1;
                wa = tab_a[st*4+ix];
                wb = tab_b[st*4+ix];
            end
        end
        return {busy, dn, stg, rd, ra, rb, tw, wr, wa, wb};
    endfunction

    function automatic logic [21:0] obs_a();
        return {busy_a, done_a, stage_a, rd_en_a, ra_a, rb_a, tw_a, wr_en_a, wa_a, wb_a};
    endfunction

    // Advance one clock; sample on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) next_cycle();
        checks++;
        if (obs_a() !== 22'd0) begin
            errors++;
            $display("FAIL reset_a: got %h expected %h", obs_a(), 22'd0);
        end
        checks++;
        if ({busy_b, done_b, stage_b, rd_en_b, ra_b, rb_b, tw_b, wr_en_b, wa_b, wb_b} !== 27'd0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0",
                     {busy_b, done_b, stage_b, rd_en_b, ra_b, rb_b, tw_b, wr_en_b, wa_b, wb_b});
        end
        rst_a = 1'b0; rst_b = 1'b0;
        next_cycle();
        checks++;
        if (obs_a() !== 22'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs_a(), 22'd0);
        end
    endtask

    task automatic test_stage_sequence();
        int rd_cnt, wr_cnt;
        rd_cnt = 0; wr_cnt = 0;
        start_a = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            next_cycle();
            start_a = 1'b0;
            checks++;
            if (obs_a() !== exp_a_vec(c)) begin
                errors++;
                $display("FAIL seq cycle %0d: got %h expected %h", c, obs_a(), exp_a_vec(c));
            end
            if (rd_en_a === 1'b1) rd_cnt++;
            if (wr_en_a === 1'b1) wr_cnt++;
        end
        checks++;
        if (rd_cnt != 12) begin
            errors++;
            $display("FAIL rd_count: got %0d expected 12", rd_cnt);
        end
        checks++;
        if (wr_cnt != 12) begin
            errors++;
            $display("FAIL wr_count: got %0d expected 12", wr_cnt);
        end
    endtask

    task automatic test_ignored_start();
        start_a = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            next_cycle();
            checks++;
            if (obs_a() !== exp_a_vec(c)) begin
                errors++;
                $display("FAIL ignored_start cycle %0d: got %h expected %h", c, obs_a(), exp_a_vec(c));
            end
            start_a = (c == 5 || c == 19);
        end
        start_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp;
        start_a = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            next_cycle();
            exp = (c <= 20) ? exp_a_vec(c) : exp_a_vec(c - 20);
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs_a(), exp);
            end
            if (c == 21) start_a = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        start_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            start_a = 1'b0;
            checks++;
            if (obs_a() !== exp_a_vec(c)) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: got %h expected %h", c, obs_a(), exp_a_vec(c));
            end
        end
        rst_a = 1'b1;
        for (int c = 9; c <= 14; c++) begin
            next_cycle();
            rst_a = 1'b0;
            checks++;
            if (obs_a() !== 22'd0) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d: got %h expected %h", c, obs_a(), 22'd0);
            end
        end
        start_a = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            next_cycle();
            start_a = 1'b0;
            checks++;
            if (obs_a() !== exp_a_vec(c)) begin
                errors++;
                $display("FAIL abort_restart cycle %0d: got %h expected %h", c, obs_a(), exp_a_vec(c));
            end
        end
    endtask

    // LOG2N=4, PIPE_LAT=1: stage s issues in cycles 1+9s..8+9s, done in 37.
    task automatic test_log2n4();
        logic [15:0] exp_rd;
        start_b = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            next_cycle();
            start_b = 1'b0;
            checks++;
            if ({busy_b, done_b} !== {(c >= 1 && c <= 37), (c == 37)}) begin
                errors++;
                $display("FAIL b_status cycle %0d: got busy=%b done=%b expected busy=%b done=%b",
                         c, busy_b, done_b, (c >= 1 && c <= 37), (c == 37));
            end
            if (c == 1) begin
                checks++;
                if ({rd_en_b, ra_b, rb_b, tw_b} !== {1'b1, 4'd0, 4'd1, 3'd0}) begin
                    errors++;
                    $display("FAIL b_first cycle 1: got rd=%b a=%0d b=%0d tw=%0d expected rd=1 a=0 b=1 tw=0",
                             rd_en_b, ra_b, rb_b, tw_b);
                end
            end
            if (c >= 28 && c <= 35) begin
                exp_rd = {4'd3, 4'(c - 28), 4'(c - 20), 1'b0, 3'(c - 28)};
                checks++;
                if ({rd_en_b, stage_b, ra_b, rb_b, 1'b0, tw_b} !== {1'b1, exp_rd}) begin
                    errors++;
                    $display("FAIL b_stage3 cycle %0d: got rd=%b st=%0d a=%0d b=%0d tw=%0d expected st=3 a=%0d b=%0d tw=%0d",
                             c, rd_en_b, stage_b, ra_b, rb_b, tw_b, c - 28, c - 20, c - 28);
                end
            end
            if (c == 36) begin
                checks++;
                if ({rd_en_b, wr_en_b, wa_b, wb_b} !== {1'b0, 1'b1, 4'd7, 4'd15}) begin
                    errors++;
                    $display("FAIL b_last_write cycle 36: got rd=%b wr=%b wa=%0d wb=%0d expected rd=0 wr=1 wa=7 wb=15",
                             rd_en_b, wr_en_b, wa_b, wb_b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stage_sequence();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        test_log2n4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
